// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared definitions for the MMIO UART/counter controller.
//   - byte offsets of the IO registers (bits [1:0] of the bus address ignored)
//   - STATUS register bit indices
//   - decoded register select enum and the address decode helper
package mmio_uart_ctrl_pkg;

   localparam logic [7:0] IO_STATUS  = 8'h00;
   localparam logic [7:0] IO_RXDATA  = 8'h04;
   localparam logic [7:0] IO_TXDATA  = 8'h08;
   localparam logic [7:0] IO_CYCLES  = 8'h10;
   localparam logic [7:0] IO_INSTRET = 8'h14;
   localparam logic [7:0] IO_CNTRST  = 8'h18;

   localparam int STAT_TX_NOT_FULL = 0;
   localparam int STAT_RX_AVAIL    = 1;
   localparam int STAT_TX_OVF      = 2;

   typedef enum logic [2:0] {
      REG_STATUS,
      REG_RXDATA,
      REG_TXDATA,
      REG_CYCLES,
      REG_INSTRET,
      REG_CNTRST,
      REG_NONE
   } io_reg_e;

   function automatic io_reg_e io_decode(input logic [7:0] addr);
      logic [7:0] word;
      word = addr & 8'hFC;
      case (word)
         IO_STATUS:  return REG_STATUS;
         IO_RXDATA:  return REG_RXDATA;
         IO_TXDATA:  return REG_TXDATA;
         IO_CYCLES:  return REG_CYCLES;
         IO_INSTRET: return REG_INSTRET;
         IO_CNTRST:  return REG_CNTRST;
         default:    return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// Bus bundle between the MEM-stage IO port / uart block and the controller.
//   io_*      : load/store port (addr, re, byte we, wdata) and registered rdata
//   tx_*      : byte stream towards the uart transmitter (valid/ready)
//   rx_*      : byte stream from the uart receiver (valid/ready)
// master = CPU + uart side, slave = the controller.
interface mmio_uart_ctrl_if;
   logic [7:0]  io_addr;
   logic        io_re;
   logic [3:0]  io_we;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   modport master (
      output io_addr, io_re, io_we, io_wdata, tx_ready, rx_data, rx_valid,
      input  io_rdata, tx_data, tx_valid, rx_ready
   );

   modport slave (
      input  io_addr, io_re, io_we, io_wdata, tx_ready, rx_data, rx_valid,
      output io_rdata, tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/mmio_uart_ctrl_fifo.sv
// Synchronous FIFO, read/write pointers plus occupancy count, head visible
// on dout without a pop (first-word fall-through).
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// A push is taken when not full or when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
module mmio_uart_ctrl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: the count gates what is ever observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller for the 0x8000_00xx IO region.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   inst_retire  : one instruction retired this cycle
//   io (slave)   : load/store port, tx stream to uart, rx stream from uart
// Holds the TX/RX byte FIFOs, the sticky TX overflow flag, the CYCLES and
// INSTRET counters, and the registered load-data mux (1-cycle latency).
module mmio_uart_ctrl
   import mmio_uart_ctrl_pkg::*;
#(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_retire,
   mmio_uart_ctrl_if.slave   io
);
   io_reg_e     sel;
   logic        tx_full, tx_empty, tx_push, tx_pop;
   logic        rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0]  tx_head, rx_head;
   logic        tx_ovf;
   logic        ovf_set, ovf_clr, cnt_clr;
   logic [31:0] cycles, instret;
   logic [31:0] status, rdata_nxt;
   logic        unused_wdata;

   assign sel = io_decode(io.io_addr);

   assign tx_push = io.io_we[0] && (sel == REG_TXDATA);
   assign tx_pop  = io.tx_valid && io.tx_ready;
   assign rx_push = io.rx_valid && io.rx_ready;
   assign rx_pop  = io.io_re && (sel == REG_RXDATA) && !rx_empty;

   // A full FIFO still takes the store if the uart drains a byte this cycle.
   assign ovf_set = tx_push && tx_full && !tx_pop;
   assign ovf_clr = io.io_we[0] && (sel == REG_STATUS) && io.io_wdata[STAT_TX_OVF];
   assign cnt_clr = (|io.io_we) && (sel == REG_CNTRST);

   assign io.tx_valid = !tx_empty;
   assign io.tx_data  = tx_head;
   assign io.rx_ready = !rx_full && !rst;

   assign unused_wdata = &{1'b0, io.io_wdata[31:8]};

   mmio_uart_ctrl_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (io.io_wdata[7:0]),
      .pop   (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   mmio_uart_ctrl_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .din   (io.rx_data),
      .pop   (rx_pop),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_comb begin
      status                   = '0;
      status[STAT_TX_NOT_FULL] = !tx_full;
      status[STAT_RX_AVAIL]    = !rx_empty;
      status[STAT_TX_OVF]      = tx_ovf;
   end

   always_comb begin
      rdata_nxt = '0;
      case (sel)
         REG_STATUS:  rdata_nxt = status;
         REG_RXDATA:  rdata_nxt = rx_empty ? 32'h0 : {24'h0, rx_head};
         REG_CYCLES:  rdata_nxt = cycles;
         REG_INSTRET: rdata_nxt = instret;
         default:     rdata_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io.io_rdata <= '0;
         tx_ovf      <= 1'b0;
         cycles      <= '0;
         instret     <= '0;
      end else begin
         if (io.io_re) io.io_rdata <= rdata_nxt;
         if (ovf_set)      tx_ovf <= 1'b1;
         else if (ovf_clr) tx_ovf <= 1'b0;
         if (cnt_clr) begin
            cycles  <= '0;
            instret <= '0;
         end else begin
            cycles  <= cycles + 32'd1;
            instret <= instret + 32'(inst_retire);
         end
      end
   end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
module tb_mmio_uart_ctrl;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inst_retire = 1'b0;

   mmio_uart_ctrl_if bus ();

   mmio_uart_ctrl #(.TX_DEPTH(D), .RX_DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_retire (inst_retire),
      .io          (bus.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model: plain queues and integers
   logic [7:0]  mtx[$];
   logic [7:0]  mrx[$];
   logic [7:0]  tx_seen[$];
   logic        movf;
   logic [31:0] mcyc, mins, mrd;
   logic [7:0]  mw;
   int          tsz, rsz;
   logic        tpop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      case (addr & 8'hFC)
         8'h00:   return {29'b0, movf, mrx.size() != 0, mtx.size() < D};
         8'h04:   return (mrx.size() != 0) ? {24'h0, mrx[0]} : 32'h0;
         8'h10:   return mcyc;
         8'h14:   return mins;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mtx.delete();
         mrx.delete();
         movf = 1'b0;
         mcyc = '0;
         mins = '0;
         mrd  = '0;
         chk_en = 1'b1;
      end else begin
         mw  = bus.io_addr & 8'hFC;
         tsz = mtx.size();
         rsz = mrx.size();
         if (bus.io_re) mrd = model_read(bus.io_addr);
         tpop = (tsz != 0) && bus.tx_ready;
         if (tpop) tx_seen.push_back(mtx.pop_front());
         if (bus.io_re && mw == 8'h04 && rsz != 0) void'(mrx.pop_front());
         if (bus.rx_valid && rsz < D) mrx.push_back(bus.rx_data);
         if (bus.io_we[0] && mw == 8'h08) begin
            if (tsz < D || tpop) mtx.push_back(bus.io_wdata[7:0]);
            else movf = 1'b1;
         end
         if (bus.io_we[0] && mw == 8'h00 && bus.io_wdata[2]) movf = 1'b0;
         if (bus.io_we != 4'h0 && mw == 8'h18) begin
            mcyc = '0;
            mins = '0;
         end else begin
            mcyc = mcyc + 32'd1;
            mins = mins + 32'(inst_retire);
         end
      end
      #2;
      if (chk_en) begin
         chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, mtx.size() != 0});
         if (mtx.size() != 0) chk("tx_data", {24'h0, bus.tx_data}, {24'h0, mtx[0]});
         chk("rx_ready", {31'b0, bus.rx_ready}, {31'b0, (mrx.size() < D) && !rst});
         chk("io_rdata", bus.io_rdata, mrd);
      end
   end

   // apply inputs at a falling edge and hold them for one full cycle
   task automatic cyc(input logic re, input logic [3:0] we, input logic [7:0] a,
                      input logic [31:0] wd);
      bus.io_re    = re;
      bus.io_we    = we;
      bus.io_addr  = a;
      bus.io_wdata = wd;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 4'h0, 8'h00, 32'h0);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      cyc(1'b1, 4'h0, a, 32'h0);
      d = bus.io_rdata;
   endtask

   logic [31:0] d;
   logic [7:0]  ra;
   int          k;

   initial begin
      bus.io_re = 1'b0; bus.io_we = 4'h0; bus.io_addr = 8'h00; bus.io_wdata = 32'h0;
      bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
      chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
      chk("rst_rdata", bus.io_rdata, 32'h0);
      rst = 1'b0;
      idle();

      // TX back-to-back with ready held high
      tx_seen.delete();
      bus.tx_ready = 1'b1;
      cyc(1'b0, 4'h1, 8'h08, 32'h41);
      cyc(1'b0, 4'h1, 8'h08, 32'h42);
      cyc(1'b0, 4'h1, 8'h08, 32'h43);
      repeat (4) idle();
      chk("tx_seq_len", tx_seen.size(), 32'd3);
      if (tx_seen.size() == 3) begin
         chk("tx_seq0", {24'h0, tx_seen[0]}, 32'h41);
         chk("tx_seq1", {24'h0, tx_seen[1]}, 32'h42);
         chk("tx_seq2", {24'h0, tx_seen[2]}, 32'h43);
      end

      // overflow with the uart stalled, then drain
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) cyc(1'b0, 4'h1, 8'h08, 32'(i));
      rd(8'h00, d); chk("status_ovf", d, 32'h4);
      tx_seen.delete();
      bus.tx_ready = 1'b1;
      repeat (10) idle();
      chk("drain_len", tx_seen.size(), 32'd8);
      for (int i = 0; i < tx_seen.size() && i < 8; i++)
         chk("drain_byte", {24'h0, tx_seen[i]}, 32'(i));

      // clear sticky overflow
      cyc(1'b0, 4'h1, 8'h00, 32'h4);
      rd(8'h00, d); chk("status_ovf_clr", d, 32'h1);

      // two received bytes
      bus.rx_valid = 1'b1; bus.rx_data = 8'h5A; idle();
      bus.rx_data = 8'hA5; idle();
      bus.rx_valid = 1'b0;
      rd(8'h00, d); chk("status_rx", d, 32'h3);
      rd(8'h04, d); chk("rx_first", d, 32'h5A);
      rd(8'h04, d); chk("rx_second", d, 32'hA5);
      rd(8'h00, d); chk("status_rx_empty", d, 32'h1);
      rd(8'h04, d); chk("rx_empty_read", d, 32'h0);

      // RX back-pressure
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin bus.rx_data = 8'(8'h10 + i); idle(); end
      bus.rx_data = 8'h18;
      chk("rx_full_ready", {31'b0, bus.rx_ready}, 32'h0);
      idle();
      rd(8'h04, d); chk("rx_full_pop", d, 32'h10);
      chk("rx_ready_again", {31'b0, bus.rx_ready}, 32'h1);
      idle();
      bus.rx_valid = 1'b0;
      for (int i = 1; i < 9; i++) begin
         rd(8'h04, d); chk("rx_drain", d, 32'(8'h10 + i));
      end

      // counters
      cyc(1'b0, 4'hF, 8'h18, 32'h0);
      for (int i = 0; i < 100; i++) begin inst_retire = (i < 37); idle(); end
      inst_retire = 1'b0;
      rd(8'h14, d); chk("instret_37", d, 32'd37);
      rd(8'h10, d); chk("cycles_101", d, 32'd101);
      cyc(1'b0, 4'h2, 8'h18, 32'h0);
      rd(8'h10, d); chk("cycles_clr", d, 32'd0);
      rd(8'h10, d); chk("cycles_resume", d, 32'd1);
      rd(8'h14, d); chk("instret_clr", d, 32'd0);

      // reset with both FIFOs occupied
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'h1, 8'h08, 32'(8'hC0 + i));
      bus.rx_valid = 1'b1; bus.rx_data = 8'h77; idle(); idle();
      bus.rx_valid = 1'b0;
      rd(8'h10, d);
      rst = 1'b1; idle();
      chk("rst2_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
      chk("rst2_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
      chk("rst2_rdata", bus.io_rdata, 32'h0);
      rst = 1'b0; idle();
      chk("rst2_rx_ready_rel", {31'b0, bus.rx_ready}, 32'h1);
      rd(8'h00, d); chk("rst2_status", d, 32'h1);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         k = $urandom_range(0, 8);
         case (k)
            0: ra = 8'h00; 1: ra = 8'h04; 2: ra = 8'h08; 3: ra = 8'h08;
            4: ra = 8'h10; 5: ra = 8'h14; 6: ra = ($urandom_range(0, 29) == 0) ? 8'h18 : 8'h0C;
            7: ra = 8'h1C; default: ra = 8'h40;
         endcase
         ra = ra | 8'($urandom_range(0, 3));
         bus.tx_ready = ($urandom_range(0, 2) != 0);
         bus.rx_valid = ($urandom_range(0, 1) != 0);
         bus.rx_data  = 8'($urandom);
         inst_retire  = ($urandom_range(0, 1) != 0);
         rst          = ($urandom_range(0, 299) == 0);
         cyc($urandom_range(0, 1) != 0, 4'($urandom), ra, $urandom);
      end
      rst = 1'b0;
      bus.rx_valid = 1'b0;
      inst_retire = 1'b0;
      idle(); idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
